vrf_banked: RTL and testbench



---
 rtl/vrf_pkg.sv | 49 ++++
 rtl/vrf_clear_seq.sv | 48 ++++
 rtl/vrf_banked.sv | 145 ++++++++++++++
 tb/tb_vrf_banked.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared definitions for the banked vector register file: default geometry,
// the clear-sequencer state type and the lane merge helper used by both the
// write path and the read bypass.
package vrf_pkg;

    // Default geometry: 16 registers of 4 x 32-bit lanes.
    localparam int VRF_NUM_REGS = 16;
    localparam int VRF_LANES    = 4;
    localparam int VRF_LANE_W   = 32;

    // Upper bounds for lane_merge operands; LANES*LANE_W must not exceed
    // VRF_MAX_DW and LANES must not exceed VRF_MAX_LANES.
    localparam int VRF_MAX_DW    = 1024;
    localparam int VRF_MAX_LANES = 32;

    // INIT: clear sequencer is zeroing the array. RUN: normal operation.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } vrf_state_t;

    // Merge two rows lane by lane: lanes whose mask bit is set come from
    // new_val, all others from old_val. Operands are zero-padded to the
    // maximum width by the caller; lane_w is the per-lane width in bits.
    // The lane mask is walked from its MSB with constant indices so the
    // function folds to plain wiring for a constant lane_w.
    function automatic logic [VRF_MAX_DW-1:0] lane_merge(
        input logic [VRF_MAX_DW-1:0]    old_val,
        input logic [VRF_MAX_DW-1:0]    new_val,
        input logic [VRF_MAX_LANES-1:0] mask,
        input int                       lane_w
    );
        logic [VRF_MAX_DW-1:0]    lane_ones;
        logic [VRF_MAX_DW-1:0]    bit_mask;
        logic [VRF_MAX_LANES-1:0] m;
        lane_ones = {VRF_MAX_DW{1'b1}} >> (VRF_MAX_DW - lane_w);
        bit_mask  = '0;
        m         = mask;
        for (int i = 0; i < VRF_MAX_LANES; i++) begin
            bit_mask = bit_mask << lane_w;
            if (m[VRF_MAX_LANES-1]) begin
                bit_mask = bit_mask | lane_ones;
            end
            m = m << 1;
        end
        return (old_val & ~bit_mask) | (new_val & bit_mask);
    endfunction

endpackage

// File: rtl/vrf_clear_seq.sv
// Clear sequencer for vrf_banked. After reset or a clr request it walks
// every register address once, emitting a clear-write strobe per edge, and
// raises ready on the edge that clears the last register.
module vrf_clear_seq
    import vrf_pkg::*;
#(
    parameter  int NUM_REGS = VRF_NUM_REGS,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output vrf_state_t    state,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

    logic [AW-1:0] cnt;

    // State, clear counter and ready flag; reset beats clr, clr restarts the walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (clr) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

    // Every INIT edge zeroes the register the counter points at.
    always_comb begin
        clr_we   = (state == INIT);
        clr_addr = cnt;
    end

endmodule

// File: rtl/vrf_banked.sv
// Banked vector register file: one storage bank per lane with per-lane
// write enables, two registered read ports and a hardware clear sequence.
// Optional feature macro: VRF_BYPASS_EN -- when defined, a read addressed
// to the register being written on the same edge returns the merged
// (post-write) row instead of the stored one.
module vrf_banked
    import vrf_pkg::*;
#(
    parameter  int NUM_REGS = VRF_NUM_REGS,
    parameter  int LANES    = VRF_LANES,
    parameter  int LANE_W   = VRF_LANE_W,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int DW       = LANES * LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             ready,
    input  logic             wre,
    input  logic [LANES-1:0] wmask,
    input  logic [AW-1:0]    a1,
    input  logic [AW-1:0]    a2,
    input  logic [AW-1:0]    a3,
    input  logic [DW-1:0]    wd3,
    output logic [DW-1:0]    rd1,
    output logic [DW-1:0]    rd2
);

    vrf_state_t    state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic             user_we;
    logic [AW-1:0]    wr_addr;
    logic [LANES-1:0] lane_we;
    logic [DW-1:0]    wr_row;
    logic [DW-1:0]    row1;
    logic [DW-1:0]    row2;

    // Zero-padded operands and results of the shared lane merge helper.
    logic [VRF_MAX_DW-1:0]    wd_pad;
    logic [VRF_MAX_LANES-1:0] mask_pad;
    logic [VRF_MAX_DW-1:0]    user_full;
    logic [DW-1:0]            user_row;
`ifdef VRF_BYPASS_EN
    logic [VRF_MAX_DW-1:0]    row1_pad;
    logic [VRF_MAX_DW-1:0]    row2_pad;
    logic [VRF_MAX_DW-1:0]    byp1_full;
    logic [VRF_MAX_DW-1:0]    byp2_full;
    logic [DW-1:0]            byp1_row;
    logic [DW-1:0]            byp2_row;
`endif
    logic                     unused_pad_bits;

    vrf_clear_seq #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .state    (state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A user write is accepted only in RUN and loses to both reset and clr.
    always_comb begin
        user_we = rst_n && !clr && (state == RUN) && wre;
    end

    // Masked write data and (optionally) bypass rows via the lane merge helper.
    always_comb begin
        wd_pad                = '0;
        wd_pad[DW-1:0]        = wd3;
        mask_pad              = '0;
        mask_pad[LANES-1:0]   = wmask;
        user_full             = lane_merge('0, wd_pad, mask_pad, LANE_W);
        user_row              = user_full[DW-1:0];
`ifdef VRF_BYPASS_EN
        row1_pad              = '0;
        row1_pad[DW-1:0]      = row1;
        row2_pad              = '0;
        row2_pad[DW-1:0]      = row2;
        byp1_full             = lane_merge(row1_pad, wd_pad, mask_pad, LANE_W);
        byp2_full             = lane_merge(row2_pad, wd_pad, mask_pad, LANE_W);
        byp1_row              = byp1_full[DW-1:0];
        byp2_row              = byp2_full[DW-1:0];
        unused_pad_bits       = ^{user_full, byp1_full, byp2_full};
`else
        unused_pad_bits       = ^user_full;
`endif
    end

    // Single array write port: clear sequencer writes all lanes with zero,
    // otherwise the user write touches only its masked lanes.
    always_comb begin
        wr_addr = a3;
        wr_row  = user_row;
        lane_we = '0;
        if (clr_we) begin
            wr_addr = clr_addr;
            wr_row  = '0;
            lane_we = '1;
        end else if (user_we) begin
            lane_we = wmask;
        end
    end

    // One storage bank per lane; writes are per-lane enabled, reads are
    // assembled into full rows and captured by the read registers below.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] bank [NUM_REGS];

        // Lane write: commits on the edge, visible to reads on the next edge.
        always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
                bank[wr_addr] <= wr_row[gi*LANE_W +: LANE_W];
            end
        end

        assign row1[gi*LANE_W +: LANE_W] = bank[a1];
        assign row2[gi*LANE_W +: LANE_W] = bank[a2];
    end

    // Registered read ports: zero in reset and INIT, stored (or bypassed) row in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (state != RUN) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
`ifdef VRF_BYPASS_EN
            rd1 <= (user_we && (a3 == a1)) ? byp1_row : row1;
            rd2 <= (user_we && (a3 == a2)) ? byp2_row : row2;
`else
            rd1 <= row1;
            rd2 <= row2;
`endif
        end
    end

endmodule

// File: tb/tb_vrf_banked.sv
// Self-checking bench for vrf_banked (default geometry 16 x 4 x 32).
// A behavioural model predicts rd1/rd2/ready for every edge; predictions are
// queued when inputs are driven and popped when the outputs are sampled.
module tb_vrf_banked;

    localparam int NR = 16;
    localparam int LN = 4;
    localparam int LW = 32;
    localparam int DW = LN * LW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          ready;
    logic          wre;
    logic [LN-1:0] wmask;
    logic [3:0]    a1;
    logic [3:0]    a2;
    logic [3:0]    a3;
    logic [DW-1:0] wd3;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    always #5 clk = ~clk;

    vrf_banked #(
        .NUM_REGS (NR),
        .LANES    (LN),
        .LANE_W   (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .ready (ready),
        .wre   (wre),
        .wmask (wmask),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          ready;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] mem_m [NR];
    bit            m_run;
    int            m_cnt;
    int            checks;
    int            errors;
    int            txn;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bits_of(input logic [LN-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LN; i++) begin
            if (m[i]) r[i*LW +: LW] = '1;
        end
        return r;
    endfunction

    // Predict this edge from the model, advance the model, then clock and compare.
    task automatic cycle();
        exp_t          e;
        exp_t          got;
        logic [DW-1:0] bm;
        bm = bits_of(wmask);
        if (!rst_n) begin
            e.rd1 = '0;
            e.rd2 = '0;
            m_run = 1'b0;
            m_cnt = 0;
        end else begin
            if (m_run) begin
                e.rd1 = mem_m[a1];
                e.rd2 = mem_m[a2];
`ifdef VRF_BYPASS_EN
                if (wre && !clr && a3 == a1) e.rd1 = (mem_m[a1] & ~bm) | (wd3 & bm);
                if (wre && !clr && a3 == a2) e.rd2 = (mem_m[a2] & ~bm) | (wd3 & bm);
`endif
            end else begin
                e.rd1 = '0;
                e.rd2 = '0;
            end
            if (clr) begin
                m_run = 1'b0;
                m_cnt = 0;
            end else if (!m_run) begin
                mem_m[m_cnt] = '0;
                if (m_cnt == NR - 1) m_run = 1'b1;
                m_cnt++;
            end else if (wre) begin
                mem_m[a3] = (mem_m[a3] & ~bm) | (wd3 & bm);
            end
        end
        e.ready = m_run;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        $display("txn %0d rst_n=%b clr=%b wre=%b a1=%0d a2=%0d a3=%0d ready=%b rd1=%h rd2=%h",
                 txn, rst_n, clr, wre, a1, a2, a3, ready, rd1, rd2);
        check_val("rd1", rd1, got.rd1);
        check_val("rd2", rd2, got.rd2);
        check_val("ready", DW'(ready), DW'(got.ready));
        txn++;
    endtask

    task automatic idle(input int n);
        wre = 1'b0;
        clr = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic write(input int addr, input logic [DW-1:0] d, input logic [LN-1:0] m);
        wre   = 1'b1;
        a3    = 4'(addr);
        wd3   = d;
        wmask = m;
        cycle();
        wre   = 1'b0;
    endtask

    task automatic read(input int x, input int y);
        a1 = 4'(x);
        a2 = 4'(y);
        cycle();
    endtask

    localparam logic [DW-1:0] VAL_A = 128'hA5A5A5A5_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [DW-1:0] VAL_B = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
    localparam logic [DW-1:0] VAL_C = 128'hCCCC0000_CCCC1111_CCCC2222_CCCC3333;
    localparam logic [DW-1:0] VAL_D = 128'hDDDDDDDD_DDDDDDDD_DDDDDDDD_DDDDDDDD;

    initial begin
        checks = 0;
        errors = 0;
        txn    = 0;
        m_run  = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < NR; i++) mem_m[i] = '0;
        rst_n = 1'b0;
        clr   = 1'b0;
        wre   = 1'b0;
        wmask = '0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        wd3   = '0;

        // Reset for two cycles, then the clear sequence runs for 16 edges.
        repeat (2) cycle();
        rst_n = 1'b1;
        idle(NR - 1);
        check_val("ready_low_edge15", DW'(ready), DW'(0));
        idle(1);
        check_val("ready_high_edge16", DW'(ready), DW'(1));
        for (int i = 0; i < NR; i++) read(i, NR - 1 - i);

        // Masked write over a full write.
        write(5, 128'h44444444_33333333_22222222_11111111, 4'b1111);
        write(5, '1, 4'b0101);
        read(5, 5);
        check_val("masked_row5", rd1, 128'h44444444_FFFFFFFF_22222222_FFFFFFFF);

        // Dual-port read, distinct and identical addresses.
        write(3, VAL_A, 4'hF);
        write(7, VAL_B, 4'hF);
        read(3, 7);
        check_val("dual_rd1", rd1, VAL_A);
        check_val("dual_rd2", rd2, VAL_B);
        read(7, 7);
        check_val("same_addr_rd1", rd1, VAL_B);
        check_val("same_addr_rd2", rd2, VAL_B);

        // Same-edge write and read of register 2.
        a1 = 4'd2;
        a2 = 4'd2;
        write(2, 128'h1, 4'hF);
`ifdef VRF_BYPASS_EN
        check_val("same_edge_rd1", rd1, 128'h1);
`else
        check_val("same_edge_rd1", rd1, 128'h0);
`endif
        read(2, 2);
        check_val("after_write_rd1", rd1, 128'h1);

        // clr with a concurrent write: write dropped, ready falls, restart on second clr.
        write(4, VAL_C, 4'hF);
        a1    = 4'd4;
        a2    = 4'd3;
        clr   = 1'b1;
        wre   = 1'b1;
        a3    = 4'd4;
        wd3   = VAL_D;
        wmask = 4'hF;
        cycle();
        clr = 1'b0;
        wre = 1'b0;
        check_val("clr_edge_ready", DW'(ready), DW'(0));
        check_val("clr_edge_rd1_old", rd1, VAL_C);
        idle(5);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        idle(NR - 1);
        check_val("reclr_ready_low", DW'(ready), DW'(0));
        idle(1);
        check_val("reclr_ready_high", DW'(ready), DW'(1));
        for (int i = 0; i < NR; i++) read(i, i);

        // Writes presented during INIT are dropped.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        idle(1);
        wre   = 1'b1;
        a3    = 4'd0;
        wd3   = '1;
        wmask = 4'hF;
        repeat (8) cycle();
        wre = 1'b0;
        idle(NR - 9);
        check_val("init_write_ready", DW'(ready), DW'(1));
        read(0, 0);
        check_val("init_write_dropped", rd1, 128'h0);

        // Random traffic in RUN.
        for (int i = 0; i < 60; i++) begin
            wre   = 1'($urandom_range(0, 1));
            wmask = 4'($urandom_range(0, 15));
            a1    = 4'($urandom_range(0, NR - 1));
            a2    = 4'($urandom_range(0, NR - 1));
            a3    = 4'($urandom_range(0, NR - 1));
            wd3   = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
